// File: rtl/datapath_sequencer_if.sv
// datapath_sequencer_if: host handshake and datapath control bundle for the sequencer
interface datapath_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             abort;
  logic             dp_dout;
  logic             busy;
  logic             done;
  logic             result;
  logic [CNT_W-1:0] op_count;
  logic             dp_clear;
  logic [2:0]       dp_w;
  logic [3:0]       dp_ce;
  logic [1:0]       dp_sel;
  logic [2:0]       dp_s;
  modport master (
    output start, abort, dp_dout,
    input  busy, done, result, op_count, dp_clear, dp_w, dp_ce, dp_sel, dp_s
  );
  modport slave (
    input  start, abort, dp_dout,
    output busy, done, result, op_count, dp_clear, dp_w, dp_ce, dp_sel, dp_s
  );
endinterface

// File: rtl/datapath_sequencer.sv
// datapath_sequencer: fixed micro-sequence FSM driving the 4-DFF serial datapath
module datapath_sequencer #(
  parameter int CLR_CYCLES = 2,
  parameter int CNT_W      = 8
) (
  input logic                 clock,
  input logic                 clear_n,
  datapath_sequencer_if.slave bus
);
  typedef enum logic [3:0] {IDLE, CLR, LD1, LD4A, LD2, LD4B, LD3, HOLD, DONE} state_t;
  state_t           state_q, state_d;
  logic [3:0]       clr_cnt_q;
  logic [CNT_W-1:0] op_count_q;
  logic             result_q;
  logic [14:0]      ctl_q;
  // Output word {busy, done, clear, w[2:0], ce[3:0], sel[1:0], s[2:0]} for a state; unused encodings look like IDLE
  function automatic logic [14:0] decode(state_t s);
    case (s)
      CLR:     decode = 15'b1_0_1_000_0000_00_000;
      LD1:     decode = 15'b1_0_0_000_0001_00_010;
      LD4A:    decode = 15'b1_0_0_000_1000_00_010;
      LD2:     decode = 15'b1_0_0_000_0010_01_001;
      LD4B:    decode = 15'b1_0_0_000_1000_01_001;
      LD3:     decode = 15'b1_0_0_100_0100_01_001;
      HOLD:    decode = 15'b1_0_0_100_0000_01_001;
      DONE:    decode = 15'b1_1_0_000_0000_00_000;
      default: decode = 15'b0;
    endcase
  endfunction
  // Next-state selection; abort overrides everything, including a start in IDLE
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = bus.start ? CLR : IDLE;
      CLR:     state_d = (clr_cnt_q == 4'(CLR_CYCLES - 1)) ? LD1 : CLR;
      LD1:     state_d = LD4A;
      LD4A:    state_d = LD2;
      LD2:     state_d = LD4B;
      LD4B:    state_d = LD3;
      LD3:     state_d = HOLD;
      HOLD:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (bus.abort) state_d = IDLE;
  end
  // State, outputs decoded from the next state so they switch with the state, and result/count capture at HOLD exit
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q    <= IDLE;
      ctl_q      <= '0;
      clr_cnt_q  <= '0;
      op_count_q <= '0;
      result_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctl_q     <= decode(state_d);
      clr_cnt_q <= (state_q == CLR) ? clr_cnt_q + 4'd1 : 4'd0;
      if (state_q == HOLD && !bus.abort) begin
        result_q   <= bus.dp_dout;
        op_count_q <= op_count_q + CNT_W'(1);
      end
    end
  end
  assign {bus.busy, bus.done, bus.dp_clear, bus.dp_w, bus.dp_ce, bus.dp_sel, bus.dp_s} = ctl_q;
  assign bus.result   = result_q;
  assign bus.op_count = op_count_q;
endmodule
